// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_pkg
//  Description : Shared definitions for the stepper pulse conditioner:
//                FSM state encoding, status bit positions, register map.
//  Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Conditioner sequencing states
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LEAD  = 3'd1,
        S_READY = 3'd2,
        S_SETUP = 3'd3,
        S_PULSE = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Status word bit positions (address 0)
    localparam int unsigned ST_LIM_FWD = 0;
    localparam int unsigned ST_LIM_REV = 1;
    localparam int unsigned ST_LIM_HIT = 2;
    localparam int unsigned ST_OVERRUN = 3;
    localparam int unsigned ST_BUSY    = 4;

    // Register map
    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_POS    = 1'b1;

endpackage : stepper_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous level input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/stepper_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_pulse_conditioner
//  Description : Converts controller en/step/dir into driver-compliant
//                signals (min pulse width, DIR setup, ENABLE lead), blocks
//                steps into asserted limits, counts emitted pulses, and
//                exposes status/position on a 2-word Avalon-MM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_pulse_conditioner
    import stepper_pkg::*;
#(
    parameter int unsigned PULSE_W   = 200,
    parameter int unsigned DIR_SETUP = 500,
    parameter int unsigned EN_LEAD   = 1000,
    parameter int unsigned TMR_W     = 16
) (
    input  logic        avs_clk,
    input  logic        avs_reset_n,
    input  logic        avs_cs,
    input  logic        avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        en_in,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        lim_fwd,
    input  logic        lim_rev,
    output logic        drv_en_n,
    output logic        drv_step,
    output logic        drv_dir
);

    localparam logic [TMR_W-1:0] C_PULSE_M1 = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] C_SETUP_M1 = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] C_LEAD_M1  = TMR_W'(EN_LEAD - 1);

    logic             w_lim_fwd_s;
    logic             w_lim_rev_s;
    logic             r_step_q;
    logic             w_rise;

    state_t           r_state,    w_state_nxt;
    logic [TMR_W-1:0] r_timer,    w_timer_nxt;
    logic             r_pending,  w_pending_nxt;
    logic             r_drv_step, w_drv_step_nxt;
    logic             r_drv_en_n, w_drv_en_n_nxt;
    logic             r_drv_dir,  w_drv_dir_nxt;

    logic             w_try_issue;
    logic             w_blocked;
    logic             w_issue;
    logic             w_lim_hit_set;
    logic             w_overrun_set;

    logic [31:0]      r_position;
    logic             r_lim_hit;
    logic             r_overrun;
    logic [31:0]      r_readdata;
    logic [31:0]      w_status;
    logic             w_busy;
    logic             w_stat_wr;
    logic             w_pos_wr;

    sync2 u_sync_lim_fwd (
        .clk   (avs_clk),
        .rst_n (avs_reset_n),
        .i_d   (lim_fwd),
        .o_q   (w_lim_fwd_s)
    );

    sync2 u_sync_lim_rev (
        .clk   (avs_clk),
        .rst_n (avs_reset_n),
        .i_d   (lim_rev),
        .o_q   (w_lim_rev_s)
    );

    // Delayed copy of step_in for rising-edge detection
    always_ff @(posedge avs_clk or negedge avs_reset_n) begin
        if (!avs_reset_n) r_step_q <= 1'b0;
        else              r_step_q <= step_in;
    end

    assign w_rise        = step_in & ~r_step_q;
    // A new edge cannot be queued while one is waiting or a pulse/gap runs
    assign w_overrun_set = w_rise & (r_pending | (r_state == S_PULSE) | (r_state == S_GAP));
    // A limit blocks motion in the direction currently presented to the driver
    assign w_blocked     = r_drv_dir ? w_lim_fwd_s : w_lim_rev_s;
    assign w_issue       = w_try_issue & ~w_blocked;
    assign w_lim_hit_set = w_try_issue &  w_blocked;

    // Sequencing state and driver output registers
    always_ff @(posedge avs_clk or negedge avs_reset_n) begin
        if (!avs_reset_n) begin
            r_state    <= S_OFF;
            r_timer    <= '0;
            r_pending  <= 1'b0;
            r_drv_step <= 1'b0;
            r_drv_en_n <= 1'b1;
            r_drv_dir  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_drv_step <= w_drv_step_nxt;
            r_drv_en_n <= w_drv_en_n_nxt;
            r_drv_dir  <= w_drv_dir_nxt;
        end
    end

    // Next-state logic: timing windows, request capture and pulse issue
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_pending_nxt  = r_pending;
        w_drv_step_nxt = r_drv_step;
        w_drv_en_n_nxt = r_drv_en_n;
        w_drv_dir_nxt  = r_drv_dir;
        w_try_issue    = 1'b0;

        case (r_state)
            S_OFF: begin
                w_drv_en_n_nxt = 1'b1;
                w_pending_nxt  = 1'b0;
                if (en_in) begin
                    w_state_nxt    = S_LEAD;
                    w_timer_nxt    = C_LEAD_M1;
                    w_drv_en_n_nxt = 1'b0;
                end
            end
            S_LEAD: begin
                if (!en_in) begin
                    w_state_nxt    = S_OFF;
                    w_drv_en_n_nxt = 1'b1;
                    w_pending_nxt  = 1'b0;
                end else begin
                    if (w_rise) w_pending_nxt = 1'b1;
                    if (r_timer == '0) w_state_nxt = S_READY;
                    else               w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_READY: begin
                if (!en_in) begin
                    w_state_nxt    = S_OFF;
                    w_drv_en_n_nxt = 1'b1;
                    w_pending_nxt  = 1'b0;
                end else if (r_pending || w_rise) begin
                    if (dir_in != r_drv_dir) begin
                        // Request stays pending through the setup window
                        w_drv_dir_nxt = dir_in;
                        w_timer_nxt   = C_SETUP_M1;
                        w_state_nxt   = S_SETUP;
                        w_pending_nxt = 1'b1;
                    end else begin
                        w_try_issue = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (!en_in) begin
                    w_state_nxt    = S_OFF;
                    w_drv_en_n_nxt = 1'b1;
                    w_pending_nxt  = 1'b0;
                end else if (r_timer == '0) begin
                    w_try_issue = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_PULSE: begin
                if (r_timer == '0) begin
                    w_drv_step_nxt = 1'b0;
                    w_timer_nxt    = C_PULSE_M1;
                    w_state_nxt    = S_GAP;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    if (en_in) begin
                        w_state_nxt = S_READY;
                    end else begin
                        w_state_nxt    = S_OFF;
                        w_drv_en_n_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_OFF;
                w_drv_en_n_nxt = 1'b1;
                w_drv_step_nxt = 1'b0;
                w_pending_nxt  = 1'b0;
            end
        endcase

        // Issue point shared by READY (same direction) and end of SETUP
        if (w_try_issue) begin
            w_pending_nxt = 1'b0;
            if (w_blocked) begin
                w_state_nxt = S_READY;
            end else begin
                w_drv_step_nxt = 1'b1;
                w_timer_nxt    = C_PULSE_M1;
                w_state_nxt    = S_PULSE;
            end
        end
    end

    assign w_stat_wr = avs_cs & avs_write & (avs_address == ADDR_STATUS);
    assign w_pos_wr  = avs_cs & avs_write & (avs_address == ADDR_POS);

    // Position counter and sticky flags; a set beats a same-cycle clear
    always_ff @(posedge avs_clk or negedge avs_reset_n) begin
        if (!avs_reset_n) begin
            r_position <= '0;
            r_lim_hit  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_pos_wr)     r_position <= avs_writedata;
            else if (w_issue) r_position <= r_position + (r_drv_dir ? 32'd1 : 32'hFFFF_FFFF);
            r_lim_hit <= w_lim_hit_set | (r_lim_hit & ~(w_stat_wr & avs_writedata[ST_LIM_HIT]));
            r_overrun <= w_overrun_set | (r_overrun & ~(w_stat_wr & avs_writedata[ST_OVERRUN]));
        end
    end

    assign w_busy = (r_state == S_SETUP) | (r_state == S_PULSE) | (r_state == S_GAP);

    // Status word assembly
    always_comb begin
        w_status             = '0;
        w_status[ST_LIM_FWD] = w_lim_fwd_s;
        w_status[ST_LIM_REV] = w_lim_rev_s;
        w_status[ST_LIM_HIT] = r_lim_hit;
        w_status[ST_OVERRUN] = r_overrun;
        w_status[ST_BUSY]    = w_busy;
    end

    // Registered read data, valid the cycle after the read strobe
    always_ff @(posedge avs_clk or negedge avs_reset_n) begin
        if (!avs_reset_n) begin
            r_readdata <= '0;
        end else if (avs_cs && avs_read) begin
            r_readdata <= (avs_address == ADDR_POS) ? r_position : w_status;
        end
    end

    assign avs_readdata = r_readdata;
    assign drv_en_n     = r_drv_en_n;
    assign drv_step     = r_drv_step;
    assign drv_dir      = r_drv_dir;

endmodule : stepper_pulse_conditioner
`default_nettype wire

// File: tb/tb_stepper_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_pulse_conditioner
//  Description : Scoreboard bench for stepper_pulse_conditioner. Stimulus
//                updates a behavioural model and queues expected pulses and
//                read data; a monitor pops and compares as the DUT responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_pulse_conditioner;

    localparam int PULSE_W   = 4;
    localparam int DIR_SETUP = 3;
    localparam int EN_LEAD   = 5;

    logic        clk = 1'b0;
    logic        avs_reset_n;
    logic        avs_cs, avs_address, avs_write, avs_read;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        en_in, step_in, dir_in, lim_fwd, lim_rev;
    logic        drv_en_n, drv_step, drv_dir;

    stepper_pulse_conditioner #(
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .EN_LEAD   (EN_LEAD),
        .TMR_W     (16)
    ) dut (
        .avs_clk       (clk),
        .avs_reset_n   (avs_reset_n),
        .avs_cs        (avs_cs),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .en_in         (en_in),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .lim_fwd       (lim_fwd),
        .lim_rev       (lim_rev),
        .drv_en_n      (drv_en_n),
        .drv_step      (drv_step),
        .drv_dir       (drv_dir)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic dir;
        int   cyc;   // expected rise cycle, -1 when not checked
    } pulse_t;

    pulse_t      pulse_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          last_rise_cyc = -100;

    // Reference model state
    logic [31:0] m_pos;
    logic        m_dir, m_lim_hit, m_ovr;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {27'b0, 1'b0, m_ovr, m_lim_hit, lim_rev, lim_fwd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_read(input logic a, input logic [31:0] exp);
        avs_cs = 1'b1; avs_read = 1'b1; avs_address = a;
        rd_q.push_back(exp);
        tick();
        avs_cs = 1'b0; avs_read = 1'b0;
        tick();
    endtask

    task automatic av_write(input logic a, input logic [31:0] d);
        avs_cs = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        if (a) m_pos = d;
        else begin
            if (d[2]) m_lim_hit = 1'b0;
            if (d[3]) m_ovr = 1'b0;
        end
        tick();
        avs_cs = 1'b0; avs_write = 1'b0;
    endtask

    // Model of one isolated step request from an idle, enabled conditioner
    task automatic model_step(input logic d);
        logic chg;
        chg   = (d != m_dir);
        m_dir = d;
        if (d ? lim_fwd : lim_rev) begin
            m_lim_hit = 1'b1;
        end else begin
            m_pos = m_pos + (d ? 32'd1 : 32'hFFFF_FFFF);
            pulse_q.push_back('{dir: d, cyc: cyc + 1 + (chg ? DIR_SETUP : 0)});
        end
    endtask

    task automatic do_step(input logic d);
        dir_in = d; step_in = 1'b1;
        model_step(d);
        tick();
        step_in = 1'b0;
        repeat (16) tick();
    endtask

    task automatic wait_step_high();
        int n;
        n = 0;
        while (!drv_step && n < 30) begin
            tick();
            n++;
        end
        chk("wait_step_high", 32'(drv_step), 32'd1);
    endtask

    // Monitor: pulse shape/timing and registered read data
    initial begin
        pulse_t e;
        logic   rd_seen;
        logic   prev_step = 1'b0, prev_dir = 1'b0, prev_en_n = 1'b1, have_fall = 1'b0;
        int     dir_chg_cyc = -100, en_fall_cyc = -100, fall_cyc = -100;
        forever begin
            @(posedge clk);
            rd_seen = avs_cs & avs_read & avs_reset_n;
            @(negedge clk);
            if (!avs_reset_n) begin
                prev_step = 1'b0; prev_dir = 1'b0; prev_en_n = 1'b1; have_fall = 1'b0;
            end else begin
                if (drv_dir !== prev_dir) dir_chg_cyc = cyc;
                if (prev_en_n && !drv_en_n) en_fall_cyc = cyc;
                if (drv_step && !prev_step) begin
                    last_rise_cyc = cyc;
                    if (pulse_q.size() == 0) begin
                        chk("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        e = pulse_q.pop_front();
                        chk("pulse_dir", 32'(drv_dir), 32'(e.dir));
                        if (e.cyc >= 0) chk("pulse_latency", 32'(cyc), 32'(e.cyc));
                    end
                    chk("dir_setup_min", 32'(int'((cyc - dir_chg_cyc) >= DIR_SETUP)), 32'd1);
                    chk("en_lead_min", 32'(int'((cyc - en_fall_cyc) >= EN_LEAD)), 32'd1);
                    if (have_fall) chk("low_time_min", 32'(int'((cyc - fall_cyc) >= PULSE_W)), 32'd1);
                end
                if (!drv_step && prev_step) begin
                    fall_cyc  = cyc;
                    have_fall = 1'b1;
                    chk("pulse_width", 32'(cyc - last_rise_cyc), 32'(PULSE_W));
                end
                if (rd_seen) begin
                    if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                    else                  chk("readdata", avs_readdata, rd_q.pop_front());
                end
                prev_step = drv_step; prev_dir = drv_dir; prev_en_n = drv_en_n;
            end
        end
    end

    initial begin
        int op;
        int n;
        avs_reset_n = 1'b0; avs_cs = 1'b0; avs_address = 1'b0; avs_write = 1'b0;
        avs_read = 1'b0; avs_writedata = '0; en_in = 1'b0; step_in = 1'b0;
        dir_in = 1'b0; lim_fwd = 1'b0; lim_rev = 1'b0;
        m_pos = '0; m_dir = 1'b0; m_lim_hit = 1'b0; m_ovr = 1'b0;
        repeat (3) tick();
        chk("rst_drv_en_n", 32'(drv_en_n), 32'd1);
        chk("rst_drv_step", 32'(drv_step), 32'd0);
        chk("rst_drv_dir", 32'(drv_dir), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        avs_reset_n = 1'b1;
        tick();
        av_read(1'b0, m_status());
        av_read(1'b1, m_pos);

        // Enable lead: step captured during lead, emitted only after it
        en_in = 1'b1;
        tick();
        chk("en_n_after_enable", 32'(drv_en_n), 32'd0);
        tick();
        dir_in = 1'b1; step_in = 1'b1;
        m_dir = 1'b1; m_pos = m_pos + 32'd1;
        pulse_q.push_back('{dir: 1'b1, cyc: -1});
        tick();
        step_in = 1'b0;
        repeat (20) tick();
        av_read(1'b1, m_pos);

        // Direction reversal
        do_step(1'b0);
        av_read(1'b1, m_pos);

        // Second edge inside pulse+gap is dropped and flagged
        dir_in = m_dir; step_in = 1'b1;
        model_step(m_dir);
        tick();
        step_in = 1'b0;
        tick(); tick();
        step_in = 1'b1;
        m_ovr = 1'b1;
        tick();
        step_in = 1'b0;
        repeat (15) tick();
        av_read(1'b0, m_status());
        av_write(1'b0, 32'h8);
        av_read(1'b0, m_status());
        av_read(1'b1, m_pos);

        // Forward limit blocks forward steps, reverse still moves
        lim_fwd = 1'b1;
        repeat (3) tick();
        do_step(1'b1);
        av_read(1'b0, m_status());
        av_read(1'b1, m_pos);
        do_step(1'b0);
        lim_fwd = 1'b0;
        repeat (3) tick();
        av_write(1'b0, 32'h4);
        av_read(1'b0, m_status());

        // Disable during a pulse: pulse and gap complete before disabling
        dir_in = m_dir; step_in = 1'b1;
        model_step(m_dir);
        tick();
        step_in = 1'b0;
        wait_step_high();
        tick();
        en_in = 1'b0;
        n = 0;
        while (!drv_en_n && n < 40) begin
            tick();
            n++;
        end
        chk("disable_after_gap", 32'(cyc - last_rise_cyc), 32'(2 * PULSE_W));
        en_in = 1'b1;
        repeat (EN_LEAD + 5) tick();

        // Position write coinciding with an issue wins over the increment
        dir_in = m_dir; step_in = 1'b1;
        avs_cs = 1'b1; avs_write = 1'b1; avs_address = 1'b1; avs_writedata = 32'h1234_5678;
        pulse_q.push_back('{dir: m_dir, cyc: cyc + 1});
        m_pos = 32'h1234_5678;
        tick();
        avs_cs = 1'b0; avs_write = 1'b0; step_in = 1'b0;
        repeat (15) tick();
        av_read(1'b1, m_pos);

        // Randomized mix of steps, limits, register accesses
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                do_step(1'($urandom_range(0, 1)));
            end else if (op == 5) begin
                lim_fwd = ($urandom_range(0, 3) == 0);
                lim_rev = ($urandom_range(0, 3) == 0);
                repeat (3) tick();
            end else if (op == 6) begin
                av_write(1'b1, $urandom);
            end else if (op == 7) begin
                av_write(1'b0, 32'($urandom_range(0, 15)));
            end else begin
                av_read(op == 9, (op == 9) ? m_pos : m_status());
            end
        end

        // Position wrap and asynchronous reset mid-pulse
        lim_fwd = 1'b0; lim_rev = 1'b0;
        repeat (3) tick();
        av_write(1'b1, 32'hFFFF_FFFF);
        do_step(1'b1);
        av_read(1'b1, m_pos);
        dir_in = 1'b1; step_in = 1'b1;
        tick();
        step_in = 1'b0;
        wait_step_high();
        #2;
        avs_reset_n = 1'b0;
        #1;
        chk("async_rst_step", 32'(drv_step), 32'd0);
        chk("async_rst_en_n", 32'(drv_en_n), 32'd1);
        m_pos = '0; m_dir = 1'b0; m_lim_hit = 1'b0; m_ovr = 1'b0;
        en_in = 1'b0;
        tick(); tick();
        avs_reset_n = 1'b1;
        tick();
        av_read(1'b0, m_status());
        av_read(1'b1, m_pos);
        repeat (5) tick();
        chk("pulses_outstanding", 32'(pulse_q.size()), 32'd0);
        chk("reads_outstanding", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_stepper_pulse_conditioner
`default_nettype wire
